// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int MAX_REQ = 16;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Counter must be able to hold the value MAX_BURST itself.
    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   idx
);

    localparam int SUM_W = PTR_W + 1;

    logic [PTR_W-1:0] cand [NUM_REQ];

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [SUM_W-1:0] sum;
        assign sum = SUM_W'(rr_ptr) + SUM_W'(gi);
        assign cand[gi] = (sum >= SUM_W'(NUM_REQ)) ? PTR_W'(sum - SUM_W'(NUM_REQ))
                                                   : PTR_W'(sum);
    end

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ burst requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    input  logic                     flush_req,
    input  logic                     fifo_full,
    output logic                     fifo_push,
    output logic [WIDTH-1:0]         fifo_wdata,
    output logic                     fifo_flush
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = burst_cnt_width(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] req_word [NUM_REQ];
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] owner_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             push;

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_split
        assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // Flush outranks everything, so it also masks the push strobe.
    assign push       = (state_q == BURST) & req[owner_q] & ~fifo_full & ~flush_req;
    assign cnt_inc    = burst_cnt_q + CNT_W'(1);
    assign owner_next = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

    assign fifo_push  = push;
    assign fifo_flush = flush_req;
    assign ack        = push ? NUM_REQ'(onehot(4'(owner_q))) : '0;
    assign fifo_wdata = (|gnt_q) ? req_word[owner_q] : '0;
    assign gnt        = gnt_q;
    assign busy       = busy_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (!flush_req && pick_valid) begin
                    state_d     = BURST;
                    owner_d     = pick_idx;
                    gnt_d       = NUM_REQ'(onehot(4'(pick_idx)));
                    busy_d      = 1'b1;
                    burst_cnt_d = '0;
                end
            end
            BURST: begin
                if (flush_req) begin
                    // rr_ptr is left alone so the flushed owner keeps its turn.
                    state_d     = IDLE;
                    gnt_d       = '0;
                    busy_d      = 1'b0;
                    burst_cnt_d = '0;
                end else if (push && (req_last[owner_q] || cnt_inc == CNT_W'(MAX_BURST))) begin
                    state_d     = IDLE;
                    rr_ptr_d    = owner_next;
                    gnt_d       = '0;
                    busy_d      = 1'b0;
                    burst_cnt_d = '0;
                end else if (push) begin
                    burst_cnt_d = cnt_inc;
                end else if (!req[owner_q]) begin
                    state_d     = IDLE;
                    rr_ptr_d    = owner_next;
                    gnt_d       = '0;
                    busy_d      = 1'b0;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed bursts, expected pushes queued in grant order.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 16;
    localparam int MAX_BURST = 4;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic                     flush_req;
    logic                     fifo_full;
    logic                     fifo_push;
    logic [WIDTH-1:0]         fifo_wdata;
    logic                     fifo_flush;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .ack        (ack),
        .gnt        (gnt),
        .busy       (busy),
        .flush_req  (flush_req),
        .fifo_full  (fifo_full),
        .fifo_push  (fifo_push),
        .fifo_wdata (fifo_wdata),
        .fifo_flush (fifo_flush)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } word_t;

    typedef struct {
        int               src;
        logic [WIDTH-1:0] data;
    } exp_t;

    word_t            wq [NUM_REQ][$];
    exp_t             exp_q [$];
    logic [NUM_REQ-1:0] ack_s;
    int               vectors;
    int               miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input int src, input logic [WIDTH-1:0] d, input logic last);
        word_t w;
        w.data = d;
        w.last = last;
        wq[src].push_back(w);
    endtask

    task automatic expect_push(input int src, input logic [WIDTH-1:0] d);
        exp_t e;
        e.src  = src;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        req      = '0;
        req_data = '0;
        req_last = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wq[i].size() > 0) begin
                req[i]                    = 1'b1;
                req_data[i*WIDTH +: WIDTH] = wq[i][0].data;
                req_last[i]               = wq[i][0].last;
            end
        end
    endtask

    // Advance one clock; a requester retires its head word when ack was seen before the edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_s[i] && wq[i].size() > 0) void'(wq[i].pop_front());
        end
        drive();
    endtask

    function automatic int pending();
        int n;
        n = exp_q.size();
        for (int i = 0; i < NUM_REQ; i++) n += wq[i].size();
        return n;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (pending() != 0 && n < 60) begin
            step();
            n++;
        end
        check(name, pending(), 0);
    endtask

    // Monitor: every push must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        ack_s = ack;
        if (fifo_push) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL push_unexpected: got data 0x%0h ack 0x%0h, required no push", fifo_wdata, ack);
            end else begin
                e = exp_q.pop_front();
                if (fifo_wdata !== e.data || ack !== NUM_REQ'(1 << e.src)) begin
                    miscompares++;
                    $display("FAIL push_data: got data 0x%0h ack 0x%0h, required data 0x%0h ack 0x%0h",
                             fifo_wdata, ack, e.data, NUM_REQ'(1 << e.src));
                end
            end
        end else if (ack !== '0) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_without_push: got ack 0x%0h, required 0", ack);
        end
    end

    int order [5] = '{0, 1, 2, 3, 0};
    int used  [NUM_REQ];

    initial begin
        vectors     = 0;
        miscompares = 0;
        ack_s       = '0;
        reset       = 1'b1;
        flush_req   = 1'b0;
        fifo_full   = 1'b0;
        drive();

        // Reset state
        @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_push", fifo_push, 0);
        check("rst_ack", ack, 0);
        check("rst_flush", fifo_flush, 0);
        check("rst_wdata", fifo_wdata, 0);
        reset = 1'b0;

        // Single requester, 3-word burst
        load(2, 16'h2A00, 1'b0);
        load(2, 16'h2A01, 1'b0);
        load(2, 16'h2A02, 1'b1);
        expect_push(2, 16'h2A00);
        expect_push(2, 16'h2A01);
        expect_push(2, 16'h2A02);
        drive();
        #1;
        check("t1_idle_no_push", fifo_push, 0);
        step();
        check("t1_gnt", gnt, 4'b0100);
        check("t1_busy", busy, 1);
        step();
        step();
        step();
        check("t1_gnt_after", gnt, 0);
        check("t1_busy_after", busy, 0);
        check("t1_rr_ptr", dut.rr_ptr_q, 3);
        drain("t1_drain");

        // Fairness: all four requesting, bursts capped at MAX_BURST
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            used[i] = 0;
            for (int k = 0; k < ((i == 0) ? 8 : 4); k++) load(i, 16'(16'h7000 + i*16 + k), 1'b0);
        end
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < MAX_BURST; k++) begin
                expect_push(order[g], 16'(16'h7000 + order[g]*16 + used[order[g]]));
                used[order[g]]++;
            end
        end
        drive();
        for (int n = 1; n <= 25; n++) begin
            step();
            check($sformatf("t2_gnt_c%0d", n), gnt,
                  (((n-1) % 5) < 4) ? 32'(1 << order[(n-1)/5]) : 32'd0);
        end
        drain("t2_drain");
        check("t2_rr_ptr", dut.rr_ptr_q, 1);

        // fifo_full stall after two words of requester 1
        for (int k = 0; k < 4; k++) begin
            load(1, 16'(16'h3100 + k), 1'b0);
            expect_push(1, 16'(16'h3100 + k));
        end
        drive();
        step();
        check("t3_gnt", gnt, 4'b0010);
        step();
        step();
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("t3_stall_push_c%0d", c), fifo_push, 0);
            check($sformatf("t3_stall_gnt_c%0d", c), gnt, 4'b0010);
            if (c == 2) check("t3_stall_cnt", dut.burst_cnt_q, 2);
            step();
        end
        fifo_full = 1'b0;
        #1;
        check("t3_resume_push", fifo_push, 1);
        check("t3_resume_data", fifo_wdata, 16'h3102);
        drain("t3_drain");
        check("t3_gnt_after", gnt, 0);
        check("t3_rr_ptr", dut.rr_ptr_q, 2);

        // Flush during requester 3's burst; requester 0 pending must not jump ahead
        load(3, 16'h4300, 1'b0);
        load(3, 16'h4301, 1'b0);
        load(3, 16'h4302, 1'b1);
        expect_push(3, 16'h4300);
        expect_push(3, 16'h4301);
        expect_push(3, 16'h4302);
        drive();
        step();
        check("t4_gnt", gnt, 4'b1000);
        step();
        flush_req = 1'b1;
        load(0, 16'h4000, 1'b1);
        expect_push(0, 16'h4000);
        drive();
        #1;
        check("t4_fifo_flush", fifo_flush, 1);
        check("t4_flush_no_push", fifo_push, 0);
        check("t4_flush_no_ack", ack, 0);
        step();
        flush_req = 1'b0;
        check("t4_gnt_idle", gnt, 0);
        check("t4_busy_idle", busy, 0);
        check("t4_rr_kept", dut.rr_ptr_q, 2);
        step();
        check("t4_regrant", gnt, 4'b1000);
        drain("t4_drain");

        // Owner drops req after one word without last
        load(1, 16'h5100, 1'b0);
        load(2, 16'h5200, 1'b1);
        expect_push(1, 16'h5100);
        expect_push(2, 16'h5200);
        drive();
        step();
        check("t5_gnt1", gnt, 4'b0010);
        step();
        check("t5_gnt1_hold", gnt, 4'b0010);
        step();
        check("t5_gnt_idle", gnt, 0);
        check("t5_rr_ptr", dut.rr_ptr_q, 2);
        check("t5_wdata_zero", fifo_wdata, 0);
        step();
        check("t5_gnt2", gnt, 4'b0100);
        drain("t5_drain");

        // Asynchronous reset mid-burst
        for (int k = 0; k < 4; k++) load(1, 16'(16'h6100 + k), 1'b0);
        expect_push(1, 16'h6100);
        drive();
        step();
        check("t6_gnt", gnt, 4'b0010);
        step();
        #1;
        check("t6_push_before", fifo_push, 1);
        #1;
        reset = 1'b1;
        #1;
        check("t6_async_gnt", gnt, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_push", fifo_push, 0);
        check("t6_async_ack", ack, 0);
        step();
        reset = 1'b0;
        load(3, 16'h6300, 1'b1);
        expect_push(1, 16'h6101);
        expect_push(1, 16'h6102);
        expect_push(1, 16'h6103);
        expect_push(3, 16'h6300);
        drive();
        step();
        check("t6_first_gnt", gnt, 4'b0010);
        drain("t6_drain");
        step();
        check("end_gnt", gnt, 0);
        check("end_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
